fetch_align_stage: RTL and testbench
====================================

Name: fetch_align_stage

Overview:
- Fetch-side stage directly upstream of the instruction queue.
- Accepts raw 10-halfword fetch packets and splits them into 16-bit (RVC) and 32-bit instructions.
- Stitches 32-bit instructions that straddle packet boundaries.
- Emits a registered aligned instruction table of up to 10 entries {PC, instr}, plus count and cut position.

Parameters:
- NHW, 10, halfwords per fetch packet (also the maximum number of entries per output).
- PCW, 32, PC width.
- ENTRY_W, 64, bits per table entry.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- i_flush  input  1  redirect/flush; synchronous, highest priority.
- i_valid  input  1  upstream packet valid.
- o_ready  output  1  stage can accept a packet this cycle.
- i_pc  input  PCW  address of halfword 0 of the packet; halfword k is at i_pc+2k.
- i_start_hw  input  4  first valid halfword index (non-zero after a mid-packet redirect).
- i_data  input  16*NHW  packet; halfword k is i_data[16k+:16].
- o_valid  output  1  output table valid.
- i_ready  input  1  downstream (queue) accepts the table.
- o_table  output  ENTRY_W*NHW  entry j is o_table[64j+:64] = {pc[31:0], instr[31:0]}.
- o_count  output  4  number of valid entries, 1..10 whenever o_valid=1.
- o_cut  output  4  o_count-1; the queue's cut position.
- o_carry  output  1  a half instruction is currently held.

Behaviour:
- Reset (rst=0, async): o_valid=0, o_table=0, o_count=0, o_cut=0, o_carry=0, state NOCARRY.
- o_ready = !o_valid || i_ready (combinational).
- Accept = i_valid && o_ready && !i_flush.
- Output register holds its value while o_valid && !i_ready.
- Latency: one cycle, from accept edge to o_valid.
- Instruction length: a halfword with bits[1:0]==2'b11 starts a 32-bit instruction; anything else is 16-bit. 16-bit instrs are zero-extended into instr[31:16].
- FSM states:
  - NOCARRY: walk starts at i_start_hw with the PC of that halfword.
  - CARRY: holds carry_hw (low half) and carry_pc.
- CARRY, continuation packet (i_pc == carry_pc+2 and i_start_hw==0):
  - Entry 0 = {carry_pc, i_data[15:0], carry_hw}.
  - Walk continues from halfword 1.
- CARRY, discontinuity (any other packet): carry discarded, packet processed as in NOCARRY.
- Walk end:
  - If the last walked position is a 32-bit start at halfword NHW-1, that halfword is captured into carry_hw/carry_pc and the next state is CARRY.
  - Otherwise the next state is NOCARRY.
  - The captured half is never emitted as an entry.
- Entries are packed from index 0 in program order. Entries >= o_count are driven to zero.
- Zero-instruction packet (e.g. start_hw=9 with a 32-bit start, or i_start_hw >= NHW):
  - Packet is consumed and o_valid is not set.
  - Carry is updated per the rules above; for i_start_hw >= NHW the carry is cleared.
- Maximum count is 10 (all RVC). Minimum non-empty count is 1.
- o_count is 4 bits and must never wrap.
- PC arithmetic is modulo 2^PCW. A packet at 0xFFFFFFEC is legal and its PCs wrap.
- i_flush=1:
  - Next edge: o_valid=0, carry cleared, state NOCARRY, table/count zeroed.
  - Any input presented in the same cycle is dropped.
  - o_ready is 1 in the following cycle.
- Simultaneous downstream take and new accept: the register reloads in the same cycle (full throughput, one packet per cycle).
- Reset mid-operation: all state, including carry and the pending output, is lost immediately.

Test Plan:
- All-RVC packet, i_pc=0x1000, start 0, accepted with i_ready=1 -> next cycle o_valid=1, o_count=10, o_cut=9, entry9 pc=0x1012.
- Packet whose halfword 9 is 0x0003-type (low half of a 32-bit instr), followed by packet i_pc=0x1014 with hw0=0xABCD -> first output has count excluding hw9 and o_carry=1; second output entry0 = {0x1012, 0xABCD0003}, o_carry=0.
- Same carry, but next packet i_pc=0x2000 -> carry dropped; entry0 pc=0x2000.
- i_start_hw=9 and hw9 is a 32-bit start -> no o_valid pulse, o_carry=1.
- i_start_hw=12 -> packet consumed, no output, carry cleared.
- i_ready=0 for 3 cycles with i_valid held -> o_table stable, o_ready=0, no loss or duplication.
- Back-to-back packets with i_ready=1 -> one table per cycle.
- i_flush with output pending and carry set -> o_valid=0, o_carry=0 next cycle.
- rst pulse mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fetch_align_stage_if.sv
// Bundle of the upstream fetch-packet handshake and the downstream aligned-table handshake.
interface fetch_align_stage_if #(
  parameter int NHW     = 10,
  parameter int PCW     = 32,
  parameter int ENTRY_W = 64
) ();
  logic                   i_flush;
  logic                   i_valid;
  logic                   o_ready;
  logic [PCW-1:0]         i_pc;
  logic [3:0]             i_start_hw;
  logic [16*NHW-1:0]      i_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [ENTRY_W*NHW-1:0] o_table;
  logic [3:0]             o_count;
  logic [3:0]             o_cut;
  logic                   o_carry;

  // Stage view: consumes packets, produces the aligned table.
  modport slave (
    input  i_flush, i_valid, i_pc, i_start_hw, i_data, i_ready,
    output o_ready, o_valid, o_table, o_count, o_cut, o_carry
  );

  // Environment view: drives packets and the downstream ready.
  modport master (
    output i_flush, i_valid, i_pc, i_start_hw, i_data, i_ready,
    input  o_ready, o_valid, o_table, o_count, o_cut, o_carry
  );
endinterface

// File: rtl/fetch_align_stage.sv
// Fetch align stage: splits 10-halfword fetch packets into RVC/32-bit
// instructions, stitches 32-bit instructions across packet boundaries and
// presents a registered table of {pc, instr} entries to the instruction queue.
module fetch_align_stage #(
  parameter int NHW     = 10,
  parameter int PCW     = 32,
  parameter int ENTRY_W = 64
) (
  input logic               clk,
  input logic               rst,
  fetch_align_stage_if.slave bus
);

  typedef enum logic [0:0] {NOCARRY = 1'b0, CARRY = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [15:0]            carry_hw_q, carry_hw_d;
  logic [PCW-1:0]         carry_pc_q, carry_pc_d;
  logic                   valid_q;
  logic [ENTRY_W*NHW-1:0] table_q, table_d;
  logic [3:0]             count_q, count_d;
  logic [3:0]             cut_q, cut_d;
  logic                   accept_s;
  logic                   cont_s;

  assign bus.o_ready = !valid_q || bus.i_ready;
  assign accept_s    = bus.i_valid && bus.o_ready && !bus.i_flush;
  assign bus.o_valid = valid_q;
  assign bus.o_table = table_q;
  assign bus.o_count = count_q;
  assign bus.o_cut   = cut_q;
  assign bus.o_carry = (state_q == CARRY);

  // Packet walk: next carry state and the packed instruction table for the incoming packet.
  always_comb begin
    logic        skip;
    logic [15:0] hw;
    logic [PCW-1:0] pc_k;
    table_d    = '0;
    count_d    = 4'd0;
    state_d    = NOCARRY;
    carry_hw_d = carry_hw_q;
    carry_pc_d = carry_pc_q;
    skip       = 1'b0;
    hw         = 16'h0000;
    pc_k       = '0;
    // A held low half only pairs with the packet that starts exactly after it.
    cont_s = (state_q == CARRY) && (bus.i_pc == carry_pc_q + PCW'(2)) &&
             (bus.i_start_hw == 4'd0);
    if (cont_s) begin
      table_d[ENTRY_W-1:0] = {carry_pc_q, bus.i_data[15:0], carry_hw_q};
      count_d = 4'd1;
      skip    = 1'b1;
    end else begin
      skip = 1'b0;
    end
    for (int k = 0; k < NHW; k++) begin
      hw   = bus.i_data[16*k +: 16];
      pc_k = bus.i_pc + PCW'(2 * k);
      if (k < int'(bus.i_start_hw)) begin
        skip = skip;
      end else if (skip) begin
        // Upper half of a 32-bit instruction already emitted.
        skip = 1'b0;
      end else if (hw[1:0] == 2'b11) begin
        if (k == NHW - 1) begin
          // Low half only: hold it until the next packet arrives.
          state_d    = CARRY;
          carry_hw_d = hw;
          carry_pc_d = pc_k;
        end else begin
          table_d[int'(count_d)*ENTRY_W +: ENTRY_W] = {pc_k, bus.i_data[16*(k+1) +: 16], hw};
          count_d = count_d + 4'd1;
          skip    = 1'b1;
        end
      end else begin
        table_d[int'(count_d)*ENTRY_W +: ENTRY_W] = {pc_k, 16'h0000, hw};
        count_d = count_d + 4'd1;
      end
    end
    if (count_d == 4'd0) begin
      cut_d = 4'd0;
    end else begin
      cut_d = count_d - 4'd1;
    end
  end

  // Carry FSM state and the held low half; updated only when a packet is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= NOCARRY;
      carry_hw_q <= 16'h0000;
      carry_pc_q <= '0;
    end else if (bus.i_flush) begin
      state_q    <= NOCARRY;
      carry_hw_q <= 16'h0000;
      carry_pc_q <= '0;
    end else if (accept_s) begin
      state_q    <= state_d;
      carry_hw_q <= carry_hw_d;
      carry_pc_q <= carry_pc_d;
    end else begin
      state_q    <= state_q;
    end
  end

  // Output table register: loads on accept, drops valid when taken, holds under back-pressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      table_q <= '0;
      count_q <= 4'd0;
      cut_q   <= 4'd0;
    end else if (bus.i_flush) begin
      valid_q <= 1'b0;
      table_q <= '0;
      count_q <= 4'd0;
      cut_q   <= 4'd0;
    end else if (accept_s) begin
      // An empty packet is consumed without raising valid.
      valid_q <= (count_d != 4'd0);
      table_q <= table_d;
      count_q <= count_d;
      cut_q   <= cut_d;
    end else if (bus.i_ready) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

endmodule

// File: tb/tb_fetch_align_stage.sv
// Directed, table-driven bench for fetch_align_stage.
module tb_fetch_align_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_align_stage_if bus ();

  fetch_align_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0]  pc;
    logic [3:0]   start;
    logic [159:0] data;
    logic         ev;
    logic [3:0]   ecount;
    logic [63:0]  e0;
    logic [63:0]  elast;
    logic         ecarry;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] rvc_pkt();
    logic [159:0] d;
    for (int k = 0; k < 10; k++) d[16*k +: 16] = 16'(k * 256 + 1);
    return d;
  endfunction

  function automatic logic [63:0] entry(input int j);
    return bus.o_table[64*j +: 64];
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [3:0] st, input logic [159:0] d);
    bus.i_valid    = 1'b1;
    bus.i_pc       = pc;
    bus.i_start_hw = st;
    bus.i_data     = d;
  endtask

  task automatic setv(input int i, input logic [31:0] pc, input logic [3:0] st, input logic [159:0] d,
                      input logic ev, input logic [3:0] ec, input logic [63:0] e0,
                      input logic [63:0] el, input logic ecar);
    vecs[i].pc = pc; vecs[i].start = st; vecs[i].data = d; vecs[i].ev = ev;
    vecs[i].ecount = ec; vecs[i].e0 = e0; vecs[i].elast = el; vecs[i].ecarry = ecar;
  endtask

  initial begin
    logic [159:0] rvc, hi3, cont, mix, wr0;
    rvc  = rvc_pkt();
    hi3  = rvc; hi3[144 +: 16] = 16'h0003;
    cont = rvc; cont[15:0] = 16'hABCD;
    wr0  = rvc; wr0[15:0] = 16'hBEEF;
    mix  = rvc;
    mix[15:0] = 16'h0003; mix[31:16] = 16'h1234; mix[47:32] = 16'h0001;
    mix[63:48] = 16'h5677; mix[79:64] = 16'h9ABC;

    setv(0,  32'h1000, 4'd0,  rvc,  1'b1, 4'd10, {32'h1000, 32'h1},          {32'h1012, 32'h0901}, 1'b0);
    setv(1,  32'h1000, 4'd0,  hi3,  1'b1, 4'd9,  {32'h1000, 32'h1},          {32'h1010, 32'h0801}, 1'b1);
    setv(2,  32'h1014, 4'd0,  cont, 1'b1, 4'd10, {32'h1012, 32'hABCD0003},   {32'h1026, 32'h0901}, 1'b0);
    setv(3,  32'h1000, 4'd0,  hi3,  1'b1, 4'd9,  {32'h1000, 32'h1},          {32'h1010, 32'h0801}, 1'b1);
    setv(4,  32'h2000, 4'd0,  rvc,  1'b1, 4'd10, {32'h2000, 32'h1},          {32'h2012, 32'h0901}, 1'b0);
    setv(5,  32'h3000, 4'd0,  mix,  1'b1, 4'd8,  {32'h3000, 32'h12340003},   {32'h3012, 32'h0901}, 1'b0);
    setv(6,  32'h4000, 4'd9,  hi3,  1'b0, 4'd0,  64'h0,                      64'h0,                1'b1);
    setv(7,  32'h5000, 4'd12, rvc,  1'b0, 4'd0,  64'h0,                      64'h0,                1'b0);
    setv(8,  32'h6000, 4'd3,  rvc,  1'b1, 4'd7,  {32'h6006, 32'h0301},       {32'h6012, 32'h0901}, 1'b0);
    setv(9,  32'hFFFFFFEC, 4'd0, rvc, 1'b1, 4'd10, {32'hFFFFFFEC, 32'h1},    {32'hFFFFFFFE, 32'h0901}, 1'b0);
    setv(10, 32'hFFFFFFEC, 4'd0, hi3, 1'b1, 4'd9,  {32'hFFFFFFEC, 32'h1},    {32'hFFFFFFFC, 32'h0801}, 1'b1);
    setv(11, 32'h0,    4'd0,  wr0,  1'b1, 4'd10, {32'hFFFFFFFE, 32'hBEEF0003}, {32'h12, 32'h0901},   1'b0);

    bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_pc = 32'h0; bus.i_start_hw = 4'd0; bus.i_data = '0;

    // Reset state
    #12;
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_count", 64'(bus.o_count), 64'd0);
    chk("rst_cut",   64'(bus.o_cut),   64'd0);
    chk("rst_carry", 64'(bus.o_carry), 64'd0);
    chk("rst_table", 64'(|bus.o_table), 64'd0);
    chk("rst_ready", 64'(bus.o_ready), 64'd1);
    @(negedge clk); rst = 1'b1;

    // Back-to-back vectors, one packet per cycle
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].pc, vecs[i].start, vecs[i].data);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 64'(bus.o_valid), 64'(vecs[i].ev));
      chk($sformatf("v%0d_carry", i), 64'(bus.o_carry), 64'(vecs[i].ecarry));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_count", i), 64'(bus.o_count), 64'(vecs[i].ecount));
        chk($sformatf("v%0d_cut", i),   64'(bus.o_cut),   64'(vecs[i].ecount - 4'd1));
        chk($sformatf("v%0d_e0", i),    entry(0), vecs[i].e0);
        chk($sformatf("v%0d_elast", i), entry(int'(vecs[i].ecount) - 1), vecs[i].elast);
        if (vecs[i].ecount < 4'd10)
          chk($sformatf("v%0d_tail", i), entry(int'(vecs[i].ecount)), 64'h0);
      end
    end
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", 64'(bus.o_valid), 64'd0);

    // Back-pressure: table held, ready low, no loss or duplication
    bus.i_ready = 1'b0;
    drive(32'h1000, 4'd0, rvc);
    @(posedge clk); #1;
    chk("bp_valid", 64'(bus.o_valid), 64'd1);
    drive(32'h2000, 4'd0, rvc);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_ready", c), 64'(bus.o_ready), 64'd0);
      chk($sformatf("bp%0d_e0", c),    entry(0), {32'h1000, 32'h1});
      chk($sformatf("bp%0d_count", c), 64'(bus.o_count), 64'd10);
    end
    bus.i_ready = 1'b1;
    #1;
    chk("bp_ready_rel", 64'(bus.o_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_next_valid", 64'(bus.o_valid), 64'd1);
    chk("bp_next_e0", entry(0), {32'h2000, 32'h1});
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_drain", 64'(bus.o_valid), 64'd0);

    // Flush with output pending and carry held
    bus.i_ready = 1'b0;
    drive(32'h1000, 4'd0, hi3);
    @(posedge clk); #1;
    chk("fl_pre_carry", 64'(bus.o_carry), 64'd1);
    bus.i_flush = 1'b1;
    drive(32'h1014, 4'd0, cont);
    @(posedge clk); #1;
    chk("fl_valid", 64'(bus.o_valid), 64'd0);
    chk("fl_carry", 64'(bus.o_carry), 64'd0);
    chk("fl_count", 64'(bus.o_count), 64'd0);
    chk("fl_ready", 64'(bus.o_ready), 64'd1);
    bus.i_flush = 1'b0; bus.i_ready = 1'b1;
    @(posedge clk); #1;
    chk("fl_post_e0", entry(0), {32'h1014, 32'h0000ABCD});
    chk("fl_post_count", 64'(bus.o_count), 64'd10);
    bus.i_valid = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-stream loses pending output and carry
    bus.i_ready = 1'b0;
    drive(32'h1000, 4'd0, hi3);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.o_valid), 64'd0);
    chk("ar_count", 64'(bus.o_count), 64'd0);
    chk("ar_cut",   64'(bus.o_cut),   64'd0);
    chk("ar_carry", 64'(bus.o_carry), 64'd0);
    chk("ar_table", 64'(|bus.o_table), 64'd0);
    @(negedge clk); rst = 1'b1; bus.i_ready = 1'b1;
    drive(32'h1014, 4'd0, cont);
    @(posedge clk); #1;
    chk("ar_post_e0", entry(0), {32'h1014, 32'h0000ABCD});
    bus.i_valid = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
